nco_sweep_ctrl: RTL

- Sweep controller that sits directly upstream of the NCO and drives its 16-bit phase_inc input.
- Steps phase_inc from a start value to a stop value, holding each value for a programmable dwell time.
- Modes: single sweep, or continuous triangle (ping-pong) sweep.
- Gives the NCO linear-stepped chirp/sweep stimulus without software touching phase_inc every cycle.

---
 rtl/nco_pkg.sv | 39 +++
 rtl/nco_dwell_timer.sv | 30 +++
 rtl/nco_sweep_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO and its sweep controller: widths, FSM states,
// sweep direction/mode encodings and the clamped step helper.
package nco_pkg;

  localparam int PHASE_W = 16;
  localparam int DWELL_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic MODE_SINGLE   = 1'b0;
  localparam logic MODE_TRIANGLE = 1'b1;

  // One step from cur toward target; the extra bit catches wrap so an overflow
  // or underflow clamps to the target instead of folding to the other end.
  function automatic logic [PHASE_W-1:0] next_toward(
    input logic [PHASE_W-1:0] cur,
    input logic [PHASE_W-1:0] step,
    input logic               dir,
    input logic [PHASE_W-1:0] target
  );
    logic [PHASE_W:0] nxt;
    logic [PHASE_W-1:0] res;
    if (dir == DIR_UP) begin
      nxt = {1'b0, cur} + {1'b0, step};
      res = (nxt[PHASE_W] || (nxt[PHASE_W-1:0] > target)) ? target : nxt[PHASE_W-1:0];
    end else begin
      nxt = {1'b0, cur} - {1'b0, step};
      res = (nxt[PHASE_W] || (nxt[PHASE_W-1:0] < target)) ? target : nxt[PHASE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter that measures how long each phase_inc value is held.
// Counts down to zero and then sits there until reloaded.
module nco_dwell_timer
  import nco_pkg::*;
#(
  parameter int W = DWELL_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Sweep controller driving the NCO phase increment: steps from start to stop,
// holding each value cfg_dwell+1 cycles, as a single sweep or a triangle.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int PHASE_W = nco_pkg::PHASE_W,
  parameter int DWELL_W = nco_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] cfg_start_inc,
  input  logic [PHASE_W-1:0] cfg_stop_inc,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_mode,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               step_strobe,
  output logic               busy,
  output logic               done
);

  // Handshake: start is a level sampled only in IDLE with abort low; abort wins
  // over start and takes effect on the next edge from any state.

  state_e state_q, state_d;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;

  // Configuration captured at start; lo/hi let one pair of targets serve both
  // an up-first and a down-first sweep.
  logic [PHASE_W-1:0] lo_r, hi_r, step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               mode_r;
  logic               cfg_load;

  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;

  logic [PHASE_W-1:0] cur_target, flip_target;

  assign cur_target  = (dir_q == DIR_UP) ? hi_r : lo_r;
  assign flip_target = (dir_q == DIR_UP) ? lo_r : hi_r;
  assign tmr_dec     = (state_q == RUN) && !abort;

  nco_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = dwell_r;
    cfg_load = 1'b0;
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cfg_load = 1'b1;
            phase_d  = cfg_start_inc;
            tmr_load = 1'b1;
            tmr_val  = cfg_dwell;
            dir_d    = (cfg_stop_inc >= cfg_start_inc) ? DIR_UP : DIR_DOWN;
            busy_d   = 1'b1;
            strobe_d = 1'b1;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (tmr_zero) begin
            if (phase_q != cur_target) begin
              phase_d  = next_toward(phase_q, step_r, dir_q, cur_target);
              tmr_load = 1'b1;
              strobe_d = 1'b1;
            end else if (mode_r == MODE_SINGLE) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else if (phase_q != flip_target) begin
              // Turnaround: the endpoint already had its dwell, so step away at once.
              dir_d    = ~dir_q;
              phase_d  = next_toward(phase_q, step_r, ~dir_q, flip_target);
              tmr_load = 1'b1;
              strobe_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= '0;
      dir_q    <= DIR_UP;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_r    <= '0;
      hi_r    <= '0;
      step_r  <= '0;
      dwell_r <= '0;
      mode_r  <= MODE_SINGLE;
    end else if (cfg_load) begin
      lo_r    <= (cfg_stop_inc >= cfg_start_inc) ? cfg_start_inc : cfg_stop_inc;
      hi_r    <= (cfg_stop_inc >= cfg_start_inc) ? cfg_stop_inc : cfg_start_inc;
      step_r  <= (cfg_step == '0) ? {{(PHASE_W-1){1'b0}}, 1'b1} : cfg_step;
      dwell_r <= cfg_dwell;
      mode_r  <= cfg_mode;
    end
  end

  assign phase_inc   = phase_q;
  assign step_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
